// File: rtl/button_poll_master.sv
// Polling Avalon-MM initiator for the button PIO. It masks PIO interrupts once after reset,
// then reads the data register periodically, debounces each button and latches press events.
module button_poll_master #(
    parameter int unsigned BTN_W        = 3,
    parameter int unsigned POLL_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 10,
    parameter int unsigned ACTIVE_LOW   = 1,
    parameter int unsigned RD_TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    input  logic             avm_readdatavalid,
    output logic [BTN_W-1:0] btn_stable,
    output logic [BTN_W-1:0] press_pulse,
    output logic             event_valid,
    output logic [BTN_W-1:0] event_code,
    input  logic             event_ack,
    output logic             err_timeout
);

    localparam int unsigned POLL_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned TO_W   = $clog2(RD_TIMEOUT + 1);
    localparam int unsigned DB_W   = 8;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;

    localparam logic [BTN_W-1:0] INV_MASK = (ACTIVE_LOW != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_RD_REQ  = 2'd2;
    localparam logic [1:0] ST_RD_WAIT = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              capture_c;
    logic              timeout_c;

    logic [POLL_W-1:0] poll_cnt;
    logic              timer_run;
    logic              timer_en_c;
    logic              tick_c;

    logic [TO_W-1:0]   to_cnt;

    logic [BTN_W-1:0]  sample;
    logic              sample_valid;

    logic [DB_W-1:0]   db_cnt      [BTN_W];
    logic [DB_W-1:0]   db_cnt_next [BTN_W];
    logic [DB_W-1:0]   db_inc;
    logic [BTN_W-1:0]  stable_next;
    logic [BTN_W-1:0]  stable_d;

    logic              unused_rd;

    assign unused_rd     = ^avm_readdata[31:BTN_W];
    assign avm_writedata = 32'h0;

    // The poll timer runs freely once IDLE has been reached; ticks outside IDLE are lost.
    assign timer_en_c = timer_run | (state == ST_IDLE);
    assign tick_c     = timer_en_c && (poll_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; capture/timeout strobes fire on the cycle a read completes.
    always_comb begin
        state_next = state;
        capture_c  = 1'b0;
        timeout_c  = 1'b0;
        case (state)
            ST_INIT: begin
                if (avm_write && !avm_waitrequest) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (tick_c) begin
                    state_next = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (avm_read && !avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        capture_c  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    capture_c  = 1'b1;
                    state_next = ST_IDLE;
                end else if (to_cnt == TO_W'(RD_TIMEOUT - 1)) begin
                    timeout_c  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Bus outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_read    <= 1'b0;
            avm_write   <= 1'b0;
            avm_address <= ADDR_DATA;
        end else begin
            avm_read    <= (state_next == ST_RD_REQ);
            avm_write   <= (state_next == ST_INIT);
            avm_address <= (state_next == ST_INIT) ? ADDR_IRQ_MASK : ADDR_DATA;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt  <= POLL_W'(POLL_DIV - 1);
            timer_run <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                timer_run <= 1'b1;
            end
            if (timer_en_c) begin
                poll_cnt <= (poll_cnt == '0) ? POLL_W'(POLL_DIV - 1) : poll_cnt - POLL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if ((state == ST_RD_WAIT) && (state_next == ST_RD_WAIT)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            sample_valid <= capture_c;
            if (capture_c) begin
                sample <= avm_readdata[BTN_W-1:0] ^ INV_MASK;
            end
            if (timeout_c) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // Per-button debounce: a new level is accepted after DEBOUNCE_CNT consecutive differing samples.
    always_comb begin
        stable_next = btn_stable;
        db_inc      = '0;
        for (int i = 0; i < BTN_W; i++) begin
            db_cnt_next[i] = db_cnt[i];
            if (sample_valid) begin
                if (sample[i] == btn_stable[i]) begin
                    db_cnt_next[i] = '0;
                end else begin
                    db_inc = (db_cnt[i] == '1) ? db_cnt[i] : db_cnt[i] + DB_W'(1);
                    if (db_inc == DB_W'(DEBOUNCE_CNT)) begin
                        stable_next[i] = sample[i];
                        db_cnt_next[i] = '0;
                    end else begin
                        db_cnt_next[i] = db_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_stable  <= '0;
            stable_d    <= '0;
            press_pulse <= '0;
            for (int i = 0; i < BTN_W; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_stable  <= stable_next;
            stable_d    <= btn_stable;
            press_pulse <= btn_stable & ~stable_d;
            for (int i = 0; i < BTN_W; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
        end
    end

    // Event latch; an ack coinciding with a pulse keeps only the new press bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_valid <= 1'b0;
            event_code  <= '0;
        end else if (event_ack && event_valid) begin
            event_code  <= press_pulse;
            event_valid <= |press_pulse;
        end else if (|press_pulse) begin
            event_code  <= event_code | press_pulse;
            event_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_button_poll_master.sv
// Directed bench for button_poll_master with a small behavioural PIO slave answering reads one cycle after acceptance.
module tb_button_poll_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_waitrequest;
    logic        avm_readdatavalid = 1'b0;
    logic [2:0]  btn_stable;
    logic [2:0]  press_pulse;
    logic        event_valid;
    logic [2:0]  event_code;
    logic        event_ack;
    logic        err_timeout;

    logic [2:0]  pio_data;
    logic        hold_valid;

    int          cyc = 0;
    int          read_count = 0;
    int          write_count = 0;
    int          last_rd_cyc = 0;
    int          rd_interval = 0;
    int          both_cnt = 0;
    logic [1:0]  last_rd_addr = 2'd3;
    logic [1:0]  last_wr_addr = 2'd0;
    logic [31:0] last_wr_data = 32'hFFFF_FFFF;
    int          pulse_cnt [3] = '{0, 0, 0};
    int          pulse_cycles = 0;

    int          base_cnt [3];
    int          base_cycles;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    button_poll_master #(
        .BTN_W        (3),
        .POLL_DIV     (8),
        .DEBOUNCE_CNT (3),
        .ACTIVE_LOW   (1),
        .RD_TIMEOUT   (15)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .btn_stable        (btn_stable),
        .press_pulse       (press_pulse),
        .event_valid       (event_valid),
        .event_code        (event_code),
        .event_ack         (event_ack),
        .err_timeout       (err_timeout)
    );

    // PIO slave model and bus/pulse monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        avm_readdatavalid <= 1'b0;
        if (avm_read && avm_write) both_cnt <= both_cnt + 1;
        if (avm_read && !avm_waitrequest) begin
            read_count   <= read_count + 1;
            last_rd_addr <= avm_address;
            rd_interval  <= cyc - last_rd_cyc;
            last_rd_cyc  <= cyc;
            if (!hold_valid) begin
                avm_readdatavalid <= 1'b1;
                avm_readdata      <= {29'd0, pio_data};
            end
        end
        if (avm_write && !avm_waitrequest) begin
            write_count  <= write_count + 1;
            last_wr_addr <= avm_address;
            last_wr_data <= avm_writedata;
        end
        if (press_pulse != 3'b000) pulse_cycles <= pulse_cycles + 1;
        for (int i = 0; i < 3; i++) begin
            if (press_pulse[i]) pulse_cnt[i] <= pulse_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) base_cnt[i] = pulse_cnt[i];
        base_cycles = pulse_cycles;
    endtask

    function automatic logic [2:0] pulse_delta();
        logic [2:0] d;
        for (int i = 0; i < 3; i++) d[i] = (pulse_cnt[i] != base_cnt[i]);
        return d;
    endfunction

    task automatic wait_read(input string tag);
        int start;
        bit seen;
        start = read_count;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (read_count != start) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic poll(input string tag);
        wait_read(tag);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        bit found;
        int wc;
        int rc;

        reset_n         = 1'b0;
        avm_waitrequest = 1'b1;
        pio_data        = 3'b111;
        hold_valid      = 1'b0;
        event_ack       = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_read",   32'(avm_read),      32'd0);
        check("rst_write",  32'(avm_write),     32'd0);
        check("rst_addr",   32'(avm_address),   32'd0);
        check("rst_wdata",  avm_writedata,      32'd0);
        check("rst_stable", 32'(btn_stable),    32'd0);
        check("rst_pulse",  32'(press_pulse),   32'd0);
        check("rst_evalid", 32'(event_valid),   32'd0);
        check("rst_ecode",  32'(event_code),    32'd0);
        check("rst_err",    32'(err_timeout),   32'd0);

        // INIT write to the IRQ mask, stalled for two cycles
        reset_n = 1'b1;
        @(negedge clk);
        check("init_write", 32'(avm_write),   32'd1);
        check("init_addr",  32'(avm_address), 32'd2);
        check("init_wdata", avm_writedata,    32'd0);
        check("init_noread", 32'(avm_read),   32'd0);
        @(negedge clk);
        check("init_hold1", 32'(avm_write),   32'd1);
        @(negedge clk);
        check("init_hold2", 32'(avm_write),   32'd1);
        check("init_hold2_addr", 32'(avm_address), 32'd2);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        check("init_done_write", 32'(avm_write),  32'd0);
        check("init_wr_count",   32'(write_count), 32'd1);
        check("init_wr_addr",    32'(last_wr_addr), 32'd2);
        check("init_wr_data",    last_wr_data,      32'd0);
        check("init_no_rd_yet",  32'(read_count),   32'd0);

        // Steady released buttons
        snap();
        poll("steady_poll1");
        poll("steady_poll2");
        poll("steady_poll3");
        check("steady_rd_addr",  32'(last_rd_addr), 32'd0);
        check("steady_interval", 32'(rd_interval >= 8), 32'd1);
        check("steady_stable",   32'(btn_stable), 32'd0);
        check("steady_pulse",    32'(pulse_cycles - base_cycles), 32'd0);
        check("steady_evalid",   32'(event_valid), 32'd0);

        // Bounce on button 0
        for (int k = 0; k < 6; k++) begin
            pio_data = (k % 2 == 0) ? 3'b110 : 3'b111;
            poll("bounce_poll");
        end
        check("bounce_stable", 32'(btn_stable), 32'd0);
        check("bounce_pulse",  32'(pulse_cycles - base_cycles), 32'd0);

        // Clean press of button 0
        pio_data = 3'b110;
        snap();
        poll("press0_poll1");
        check("press0_s1_stable", 32'(btn_stable), 32'd0);
        poll("press0_poll2");
        check("press0_s2_stable", 32'(btn_stable), 32'd0);
        poll("press0_poll3");
        check("press0_stable",   32'(btn_stable), 32'd1);
        check("press0_pbits",    32'(pulse_delta()), 32'd1);
        check("press0_pcycles",  32'(pulse_cycles - base_cycles), 32'd1);
        check("press0_evalid",   32'(event_valid), 32'd1);
        check("press0_ecode",    32'(event_code), 32'd1);

        // Press button 2, ack coinciding with its pulse
        pio_data = 3'b010;
        snap();
        poll("press2_poll1");
        poll("press2_poll2");
        check("press2_pre_stable", 32'(btn_stable), 32'd1);
        check("press2_pre_ecode",  32'(event_code), 32'd1);
        wait_read("press2_poll3");
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (press_pulse != 3'b000) found = 1'b1;
            else @(negedge clk);
        end
        check("press2_pulse_seen", 32'(found), 32'd1);
        check("press2_pulse_val",  32'(press_pulse), 32'd4);
        event_ack = 1'b1;
        @(negedge clk);
        event_ack = 1'b0;
        check("ackpulse_ecode",  32'(event_code), 32'd4);
        check("ackpulse_evalid", 32'(event_valid), 32'd1);
        check("ackpulse_stable", 32'(btn_stable), 32'd5);
        @(negedge clk);
        check("press2_pcycles", 32'(pulse_cycles - base_cycles), 32'd1);
        check("press2_pbits",   32'(pulse_delta()), 32'd4);

        // Ack alone clears, ack while empty does nothing
        event_ack = 1'b1;
        @(negedge clk);
        event_ack = 1'b0;
        check("ack_evalid", 32'(event_valid), 32'd0);
        check("ack_ecode",  32'(event_code), 32'd0);
        event_ack = 1'b1;
        @(negedge clk);
        event_ack = 1'b0;
        check("ack_empty_evalid", 32'(event_valid), 32'd0);

        // Release both buttons: 1->0 gives no pulse
        pio_data = 3'b111;
        snap();
        poll("release_poll1");
        poll("release_poll2");
        poll("release_poll3");
        check("release_stable", 32'(btn_stable), 32'd0);
        check("release_pulse",  32'(pulse_cycles - base_cycles), 32'd0);
        check("release_evalid", 32'(event_valid), 32'd0);

        // Read timeout
        hold_valid = 1'b1;
        wait_read("to_read");
        repeat (14) @(negedge clk);
        check("to_err_before", 32'(err_timeout), 32'd0);
        @(negedge clk);
        check("to_err_after", 32'(err_timeout), 32'd1);
        check("to_read_low",  32'(avm_read), 32'd0);
        repeat (5) @(negedge clk);
        hold_valid = 1'b0;
        poll("to_resume");
        check("to_err_sticky", 32'(err_timeout), 32'd1);
        check("to_stable",     32'(btn_stable), 32'd0);

        // Reset asserted while a read is stalled in RD_REQ
        avm_waitrequest = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (avm_read) found = 1'b1;
        end
        check("rdreq_seen", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_read",  32'(avm_read), 32'd0);
        check("midrst_write", 32'(avm_write), 32'd0);
        check("midrst_err",   32'(err_timeout), 32'd0);
        wc = write_count;
        rc = read_count;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reinit_write", 32'(avm_write), 32'd1);
        check("reinit_addr",  32'(avm_address), 32'd2);
        check("reinit_noread", 32'(avm_read), 32'd0);
        @(negedge clk);
        check("reinit_wr_count", 32'(write_count - wc), 32'd1);
        check("reinit_rd_count", 32'(read_count - rc), 32'd0);
        check("reinit_done",     32'(avm_write), 32'd0);
        wait_read("reinit_poll");
        check("no_rd_wr_overlap", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
